// File: rtl/serial_deser_8b.sv
// Serial-to-parallel deserializer: packs one accepted bit per cycle into an NBITS word.
// Latency: a word is presented on out/out_val the cycle after its last bit is accepted.
// Backpressure: in_rdy drops only when the word-completing bit would hit a full, non-draining output buffer.
module serial_deser_8b #(
  parameter int NBITS     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic                     in_,
  input  logic                     clear,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [NBITS-1:0]         out,
  output logic [$clog2(NBITS)-1:0] bit_cnt
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  logic [NBITS-1:0] sreg;
  logic [NBITS-1:0] sreg_nxt;
  logic [NBITS-1:0] obuf;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    pos;
  logic             is_last;
  logic             xfer;
  logic             done;

  // The bit being accepted now is the last one of the word.
  assign is_last = (cnt == LAST);

  // Only the word-completing bit can stall, and only if the buffer cannot hand off its word this cycle.
  assign in_rdy = !clear && (!is_last || !out_val || out_rdy);

  assign xfer = in_val && in_rdy;
  assign done = xfer && is_last;

  // Bit k of a word lands at position k (LSB first) or NBITS-1-k (MSB first).
  assign pos = MSB_FIRST ? (LAST - cnt) : cnt;

  // Partial word with the incoming bit merged in; unwritten positions are still zero.
  always_comb begin
    sreg_nxt      = sreg;
    sreg_nxt[pos] = in_;
  end

  // Partial-word assembly: clear and word completion both restart from an empty word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (clear) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (xfer) begin
      if (is_last) begin
        cnt  <= '0;
        sreg <= '0;
      end else begin
        cnt  <= cnt + CW'(1);
        sreg <= sreg_nxt;
      end
    end
  end

  // Output buffer: loads only on completion, so out holds its last word after it drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obuf    <= '0;
      out_val <= 1'b0;
    end else if (done) begin
      obuf    <= sreg_nxt;
      out_val <= 1'b1;
    end else if (out_val && out_rdy) begin
      out_val <= 1'b0;
    end
  end

  assign out     = obuf;
  assign bit_cnt = cnt;

endmodule

// File: tb/tb_serial_deser_8b.sv
// Self-checking bench: two DUTs (LSB-first and MSB-first) share stimulus; a scoreboard queue
// of expected words is filled by a bit-counting reference model and drained by a monitor
// whenever a word is handed off (out_val && out_rdy).
module tb_serial_deser_8b;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val, in_, clear, out_rdy;
  logic       in_rdy0, in_rdy1, out_val0, out_val1;
  logic [7:0] out0, out1;
  logic [2:0] bit_cnt0, bit_cnt1;

  int checks = 0;
  int passes = 0;

  // Reference model: bits collected so far, whether a word is waiting, expected words in order.
  int         m_cnt;
  logic [7:0] m_bits;
  bit         m_pend;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  serial_deser_8b #(.NBITS(N), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy0), .in_(in_),
    .clear(clear), .out_val(out_val0), .out_rdy(out_rdy), .out(out0), .bit_cnt(bit_cnt0)
  );

  serial_deser_8b #(.NBITS(N), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy1), .in_(in_),
    .clear(clear), .out_val(out_val1), .out_rdy(out_rdy), .out(out1), .bit_cnt(bit_cnt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // Monitor: every handoff must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (!reset && out_val0 && out_rdy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_word", 1, 0);
      end else begin
        logic [7:0] w;
        w = exp_q.pop_front();
        chk("word_lsb_first", int'(out0), int'(w));
        chk("word_msb_first", int'(out1), int'(rev8(w)));
      end
    end
  end

  // One clock cycle: drive inputs between edges, check handshake/state against the model,
  // then advance the model to what the coming rising edge should do.
  task automatic cycle(input bit v, input bit b, input bit clr, input bit ordy);
    bit exp_rdy, drain, completes;
    @(posedge clk);
    #2;
    in_val  = v;
    in_     = b;
    clear   = clr;
    out_rdy = ordy;
    #1;
    exp_rdy = !clr && (m_cnt != N - 1 || !m_pend || ordy);
    chk("in_rdy_lsb", int'(in_rdy0), int'(exp_rdy));
    chk("in_rdy_msb", int'(in_rdy1), int'(exp_rdy));
    chk("bit_cnt", int'(bit_cnt0), m_cnt);
    chk("bit_cnt_msb", int'(bit_cnt1), m_cnt);
    chk("out_val", int'(out_val0), int'(m_pend));
    chk("out_val_msb", int'(out_val1), int'(m_pend));
    drain     = m_pend && ordy;
    completes = 1'b0;
    if (clr) begin
      m_cnt  = 0;
      m_bits = '0;
    end else if (v && exp_rdy) begin
      m_bits[m_cnt] = b;
      m_cnt++;
      if (m_cnt == N) begin
        exp_q.push_back(m_bits);
        m_cnt     = 0;
        m_bits    = '0;
        completes = 1'b1;
      end
    end
    if (completes) m_pend = 1'b1;
    else if (drain) m_pend = 1'b0;
  endtask

  // Sends the bits of w in order w[0], w[1], ... (stalled bits are retried).
  task automatic send_word(input logic [7:0] w, input bit ordy);
    for (int k = 0; k < N; k++) cycle(1'b1, w[k], 1'b0, ordy);
  endtask

  initial begin
    logic [7:0] word_a, word_b, word_c;
    reset = 1'b1; in_val = 1'b0; in_ = 1'b0; clear = 1'b0; out_rdy = 1'b0;
    m_cnt = 0; m_bits = '0; m_pend = 1'b0;
    #3;
    chk("reset_out_val", int'(out_val0), 0);
    chk("reset_out", int'(out0), 0);
    chk("reset_bit_cnt", int'(bit_cnt0), 0);
    @(posedge clk); #2 reset = 1'b0;

    // Stream 1,0,1,1,0,0,0,1: 8'h8D LSB first, 8'hB1 MSB first.
    word_a = 8'b1000_1101;
    send_word(word_a, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("directed_8d", int'(out0), 8'h8D);
    chk("directed_b1", int'(out1), 8'hB1);

    // Backpressure: A waits, B's 8th bit stalls until out_rdy rises, then A hands off gap-free.
    word_b = 8'h5A;
    send_word(word_a, 1'b0);
    for (int k = 0; k < N - 1; k++) cycle(1'b1, word_b[k], 1'b0, 1'b0);
    cycle(1'b1, word_b[7], 1'b0, 1'b0);
    cycle(1'b1, word_b[7], 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("backpressure_b", int'(out0), int'(word_b));
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: 24 bits, no stalls, three one-cycle pulses.
    for (int i = 0; i < 3 * N; i++) cycle(1'b1, 1'($urandom_range(1)), 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Clear: pending word survives, 3 partial bits dropped, next 8 bits form a full word.
    word_c = 8'hE7;
    send_word(8'h3C, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    send_word(word_c, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("after_clear_word", int'(out0), int'(word_c));

    // Asynchronous reset mid-word with a pending word.
    send_word(8'h96, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    in_val = 1'b0; clear = 1'b0; out_rdy = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_out_val", int'(out_val0), 0);
    chk("async_out", int'(out0), 0);
    chk("async_out_msb", int'(out1), 0);
    chk("async_bit_cnt", int'(bit_cnt0), 0);
    m_cnt = 0; m_bits = '0; m_pend = 1'b0;
    exp_q.delete();
    @(posedge clk); #2 reset = 1'b0;
    send_word(8'hC3, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_reset_word", int'(out0), 8'hC3);

    // Randomized traffic with sporadic clears and random consumer readiness.
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(3) != 0), 1'($urandom_range(1)),
            ($urandom_range(24) == 0), ($urandom_range(4) < 3));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
